// File: rtl/btb_fetch.sv
// rtl/btb_fetch.sv - Fetch-PC register with a direct-mapped branch target buffer
//
// Holds the fetch PC and a 2**INDEX_SIZE-entry direct-mapped BTB. Each cycle
// the BTB is looked up with pcF; the next PC is chosen from redirect,
// stall, predicted-taken target or the sequential PC.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   stallF          hold pcF
//   BpredF          taken/not-taken direction for the current pcF
//   redirectD       load redirect_pcD into pcF (wins over stallF)
//   redirect_pcD    corrected fetch PC
//   BtbWriteD       install/overwrite the entry for pcD with br_targetD
//   pcD             PC of the resolved control-transfer instruction
//   br_targetD      resolved target for pcD
//   btb_flush       invalidate all entries (wins over BtbWriteD)
//   pcF             registered fetch PC
//   pc_plus4F       pcF + 4
//   btb_hitF        valid tag match for pcF
//   pred_takenF     btb_hitF & BpredF
//   pred_targetF    stored target on a hit, else 0

module btb_fetch #(
    parameter int          INDEX_SIZE = 6,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        BpredF,
    input  logic        redirectD,
    input  logic [31:0] redirect_pcD,
    input  logic        BtbWriteD,
    input  logic [31:0] pcD,
    input  logic [31:0] br_targetD,
    input  logic        btb_flush,
    output logic [31:0] pcF,
    output logic [31:0] pc_plus4F,
    output logic        btb_hitF,
    output logic        pred_takenF,
    output logic [31:0] pred_targetF
);

    localparam int ENTRIES = 1 << INDEX_SIZE;
    localparam int TAG_W   = 30 - INDEX_SIZE;

    logic [31:0]           pc_q, pc_d;
    logic                  valid_q  [ENTRIES];
    logic                  valid_d  [ENTRIES];
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [TAG_W-1:0]      tag_d    [ENTRIES];
    logic [31:0]           target_q [ENTRIES];
    logic [31:0]           target_d [ENTRIES];

    logic [INDEX_SIZE-1:0] rd_idx;
    logic [TAG_W-1:0]      rd_tag;
    logic [INDEX_SIZE-1:0] wr_idx;
    logic [TAG_W-1:0]      wr_tag;

    assign rd_idx = pc_q[INDEX_SIZE+1:2];
    assign rd_tag = pc_q[31:INDEX_SIZE+2];
    assign wr_idx = pcD[INDEX_SIZE+1:2];
    assign wr_tag = pcD[31:INDEX_SIZE+2];

    // Lookup reads the registered arrays, so a write in this cycle is only
    // seen from the next cycle on.
    assign pcF          = pc_q;
    assign pc_plus4F    = pc_q + 32'd4;
    assign btb_hitF     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign pred_takenF  = btb_hitF && BpredF;
    assign pred_targetF = btb_hitF ? target_q[rd_idx] : 32'd0;

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (redirectD) begin
            pc_d = redirect_pcD;
        end else if (stallF) begin
            pc_d = pc_q;
        end else if (pred_takenF) begin
            pc_d = pred_targetF;
        end
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (btb_flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (BtbWriteD && !reset) begin
            valid_d[wr_idx]  = 1'b1;
            tag_d[wr_idx]    = wr_tag;
            target_d[wr_idx] = br_targetD;
        end
    end

    // Tags and targets carry no reset; clearing the valid bits is enough.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        if (reset) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_btb_fetch.sv
// tb/tb_btb_fetch.sv - Self-checking bench for btb_fetch
module tb_btb_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, stallF, BpredF, redirectD, BtbWriteD, btb_flush;
    logic [31:0] redirect_pcD, pcD, br_targetD;
    logic [31:0] pcF, pc_plus4F, pred_targetF;
    logic        btb_hitF, pred_takenF;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    btb_fetch #(.INDEX_SIZE(6), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .stallF(stallF), .BpredF(BpredF),
        .redirectD(redirectD), .redirect_pcD(redirect_pcD),
        .BtbWriteD(BtbWriteD), .pcD(pcD), .br_targetD(br_targetD),
        .btb_flush(btb_flush), .pcF(pcF), .pc_plus4F(pc_plus4F),
        .btb_hitF(btb_hitF), .pred_takenF(pred_takenF),
        .pred_targetF(pred_targetF)
    );

    typedef struct {
        logic        rst, stall, bpred, redir;
        logic [31:0] rpc;
        logic        wr;
        logic [31:0] pcd, tgt;
        logic        fl;
        logic [31:0] e_pc;
        logic        e_hit;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t tbl[$];

    // Reference BTB: remembers the full PC written at each slot.
    bit          m_valid [64];
    logic [31:0] m_pc    [64];
    logic [31:0] m_tgt   [64];
    logic [31:0] m_pcf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, stall, bpred, redir, input logic [31:0] rpc,
                                input logic wr, input logic [31:0] pcd, tgt, input logic fl,
                                input logic [31:0] e_pc, input logic e_hit, input logic [31:0] e_tgt);
        vec_t v;
        v.rst = rst; v.stall = stall; v.bpred = bpred; v.redir = redir; v.rpc = rpc;
        v.wr = wr; v.pcd = pcd; v.tgt = tgt; v.fl = fl;
        v.e_pc = e_pc; v.e_hit = e_hit; v.e_tgt = e_tgt;
        return v;
    endfunction

    task automatic drive(input logic rst, stall, bpred, redir, input logic [31:0] rpc,
                         input logic wr, input logic [31:0] pcd, tgt, input logic fl);
        reset = rst; stallF = stall; BpredF = bpred; redirectD = redir; redirect_pcD = rpc;
        BtbWriteD = wr; pcD = pcd; br_targetD = tgt; btb_flush = fl;
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 4) % 64);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        int i;
        i = idx_of(a);
        return m_valid[i] && (m_pc[i] / 256 == a / 256);
    endfunction

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        #3;
        chk("reset_pc", pcF, RST_PC);
        chk("reset_plus4", pc_plus4F, RST_PC + 32'd4);
        chk("reset_hit", {31'd0, btb_hitF}, 32'd0);
        chk("reset_taken", {31'd0, pred_takenF}, 32'd0);
        chk("reset_tgt", pred_targetF, 32'd0);
        tick();

        //        rst st bp rd rpc          wr pcd     tgt          fl  e_pc          hit e_tgt
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,      0,           0, 32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,      0,           0, 32'h4,        0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            1, 32'h10, 32'h200,     0, 32'h8,        0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,      0,           0, 32'hC,        0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0,            0, 0,      0,           0, 32'h10,       1, 32'h200));
        tbl.push_back(mk(0, 0, 0, 1, 32'h10,       0, 0,      0,           0, 32'h200,      0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,      0,           0, 32'h10,       1, 32'h200));
        tbl.push_back(mk(0, 0, 0, 0, 0,            1, 32'h110,32'h300,     0, 32'h14,       0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h10,       0, 0,      0,           0, 32'h18,       0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0,            0, 0,      0,           0, 32'h10,       0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h110,      0, 0,      0,           0, 32'h14,       0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0,            0, 0,      0,           0, 32'h110,      1, 32'h300));
        tbl.push_back(mk(0, 1, 0, 1, 32'h400,      0, 0,      0,           0, 32'h300,      0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,            0, 0,      0,           0, 32'h400,      0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,            0, 0,      0,           0, 32'h400,      0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            1, 32'h20, 32'h500,     1, 32'h400,      0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h20,       0, 0,      0,           0, 32'h404,      0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0,            0, 0,      0,           0, 32'h20,       0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h30,       0, 0,      0,           0, 32'h24,       0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0,            1, 32'h30, 32'h600,     0, 32'h30,       0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0,            0, 0,      0,           0, 32'h30,       1, 32'h600));
        tbl.push_back(mk(0, 0, 0, 1, 32'h110,      0, 0,      0,           0, 32'h600,      0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0,            0, 0,      0,           0, 32'h110,      0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFC,0, 0,      0,           0, 32'h114,      0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,      0,           0, 32'hFFFF_FFFC,0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 32'h800,      1, 32'h34, 32'h700,     0, 32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h30,       0, 0,      0,           0, RST_PC,       0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0,            0, 0,      0,           0, 32'h30,       0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 32'h6,        0, 0,      0,           0, 32'h34,       0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,      0,           0, 32'h6,        0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,      0,           0, 32'hA,        0, 0));

        foreach (tbl[k]) begin
            drive(tbl[k].rst, tbl[k].stall, tbl[k].bpred, tbl[k].redir, tbl[k].rpc,
                  tbl[k].wr, tbl[k].pcd, tbl[k].tgt, tbl[k].fl);
            #3;
            chk($sformatf("vec%0d_pc", k), pcF, tbl[k].e_pc);
            chk($sformatf("vec%0d_plus4", k), pc_plus4F, tbl[k].e_pc + 32'd4);
            chk($sformatf("vec%0d_hit", k), {31'd0, btb_hitF}, {31'd0, tbl[k].e_hit});
            chk($sformatf("vec%0d_taken", k), {31'd0, pred_takenF},
                {31'd0, tbl[k].e_hit & tbl[k].bpred});
            chk($sformatf("vec%0d_tgt", k), pred_targetF, tbl[k].e_tgt);
            tick();
        end

        // Writes proceed during a long stall; the stalled PC then hits.
        drive(0, 0, 0, 1, 32'h80, 0, 0, 0, 0);
        tick();
        drive(0, 1, 1, 0, 0, 1, 32'h80, 32'h1234, 0);
        tick();
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        #3;
        chk("stall_pc", pcF, 32'h80);
        chk("stall_hit", {31'd0, btb_hitF}, 32'd1);
        chk("stall_tgt", pred_targetF, 32'h1234);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        #3;
        chk("stall_release_pc", pcF, 32'h1234);
        tick();

        // Randomized run against the reference model.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        m_pcf = RST_PC;
        for (int i = 0; i < 64; i++) m_valid[i] = 0;
        for (int n = 0; n < 400; n++) begin
            logic        r_rst, r_st, r_bp, r_rd, r_wr, r_fl;
            logic [31:0] r_rpc, r_pcd, r_tgt, nxt;
            bit          h;
            r_rst = ($urandom_range(0, 59) == 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_bp  = $urandom_range(0, 1);
            r_rd  = ($urandom_range(0, 5) == 0);
            r_wr  = ($urandom_range(0, 2) == 0);
            r_fl  = ($urandom_range(0, 39) == 0);
            r_rpc = $urandom_range(0, 63) * 4 + ($urandom_range(0, 1) ? 32'h100 : 32'h0);
            r_pcd = $urandom_range(0, 63) * 4 + ($urandom_range(0, 1) ? 32'h100 : 32'h0);
            r_tgt = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 127) * 4;
            drive(r_rst, r_st, r_bp, r_rd, r_rpc, r_wr, r_pcd, r_tgt, r_fl);
            #3;
            h = m_hit(m_pcf);
            chk("rnd_pc", pcF, m_pcf);
            chk("rnd_plus4", pc_plus4F, m_pcf + 32'd4);
            chk("rnd_hit", {31'd0, btb_hitF}, {31'd0, h});
            chk("rnd_taken", {31'd0, pred_takenF}, {31'd0, h && r_bp});
            chk("rnd_tgt", pred_targetF, h ? m_tgt[idx_of(m_pcf)] : 32'd0);
            if (r_rd)           nxt = r_rpc;
            else if (r_st)      nxt = m_pcf;
            else if (h && r_bp) nxt = m_tgt[idx_of(m_pcf)];
            else                nxt = m_pcf + 32'd4;
            if (r_rst) begin
                m_pcf = RST_PC;
                for (int i = 0; i < 64; i++) m_valid[i] = 0;
            end else begin
                m_pcf = nxt;
                if (r_fl) begin
                    for (int i = 0; i < 64; i++) m_valid[i] = 0;
                end else if (r_wr) begin
                    m_valid[idx_of(r_pcd)] = 1;
                    m_pc[idx_of(r_pcd)]    = r_pcd;
                    m_tgt[idx_of(r_pcd)]   = r_tgt;
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btb_fetch.md
BTB_FETCH -- requirements
Module: btb_fetch

Interface
REQ-001 Parameter INDEX_SIZE, default 6: log2 of the number of BTB entries.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: fetch PC loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stallF  input  1  hold pcF; no fetch-PC advance.
REQ-006 BpredF  input  1  direction prediction for the current pcF (1 = taken).
REQ-007 redirectD  input  1  decode detected a mispredict; load redirect_pcD.
REQ-008 redirect_pcD  input  32  corrected fetch PC.
REQ-009 BtbWriteD  input  1  install or update the BTB entry for pcD.
REQ-010 pcD  input  32  PC of the resolved control-transfer instruction.
REQ-011 br_targetD  input  32  resolved target of the instruction at pcD.
REQ-012 btb_flush  input  1  invalidate every BTB entry.
REQ-013 pcF  output  32  current fetch PC, registered.
REQ-014 pc_plus4F  output  32  pcF + 4, combinational.
REQ-015 btb_hitF  output  1  valid tag match for pcF, combinational.
REQ-016 pred_takenF  output  1  btb_hitF AND BpredF.
REQ-017 pred_targetF  output  32  stored target on a hit, otherwise 0.

Function
REQ-018 The BTB SHALL be direct-mapped with 2**INDEX_SIZE entries; each entry holds a valid bit, a tag and a 32-bit target.
REQ-019 Read index SHALL be pcF[INDEX_SIZE+1:2]; tag SHALL be pcF[31:INDEX_SIZE+2]. pcD SHALL use the same fields for writes.
REQ-020 btb_hitF SHALL be 1 iff the entry at the read index is valid and its tag equals the pcF tag.
REQ-021 Next-PC priority SHALL be: reset > redirectD > stallF > pred_takenF > sequential.
  - redirectD: pcF <= redirect_pcD, even while stallF = 1.
  - stallF (no redirect): pcF holds.
  - pred_takenF: pcF <= pred_targetF.
  - else: pcF <= pcF + 4; 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-022 Redirect latency SHALL be one cycle: pcF equals redirect_pcD in the cycle after redirectD is sampled.
REQ-023 On BtbWriteD = 1, the entry at the pcD index SHALL be written: valid = 1, tag from pcD, target = br_targetD. An existing entry, including one with a different tag, is overwritten.
REQ-024 A write SHALL become visible to reads on the next cycle. A same-cycle read of the written index returns the old contents.
REQ-025 btb_flush SHALL clear all valid bits in one cycle and SHALL take precedence over a same-cycle BtbWriteD, which is then dropped.
REQ-026 BTB writes and flushes SHALL proceed regardless of stallF and redirectD.
REQ-027 pcF[1:0] SHALL carry whatever redirect_pcD or the stored target supplies; no alignment is enforced.
REQ-028 Tags and targets SHALL need no reset; only valid bits and pcF are reset.

Reset
REQ-029 While reset = 1 at a rising edge, pcF SHALL load RESET_PC, all valid bits SHALL clear, and any BtbWriteD SHALL be ignored.
REQ-030 After reset, btb_hitF = 0, pred_takenF = 0, pred_targetF = 0 and pc_plus4F = RESET_PC + 4.
REQ-031 Asserting reset mid-run SHALL discard any pending redirect and all BTB contents on that edge.

Verification
REQ-032 Reset, then 3 free-running cycles -> pcF = 0, 4, 8, 12; btb_hitF = 0 throughout.
REQ-033 BtbWriteD with pcD = 0x10 and br_targetD = 0x200; BpredF = 1 when pcF reaches 0x10 -> btb_hitF = 1, pred_takenF = 1, next pcF = 0x200. With BpredF = 0 -> next pcF = 0x14.
REQ-034 Aliasing: write pcD = 0x10, then pcD = 0x110 (INDEX_SIZE = 6, same index, different tag); fetch 0x10 -> btb_hitF = 0; fetch 0x110 -> hit, target = the second br_targetD.
REQ-035 stallF = 1 and redirectD = 1 with redirect_pcD = 0x400 in the same cycle -> pcF = 0x400 next cycle; then stallF alone -> pcF stays 0x400.
REQ-036 btb_flush and BtbWriteD in the same cycle (pcD = 0x20) -> fetch 0x20 later gives btb_hitF = 0. Write at the pcF index in the cycle pcF is read -> that cycle shows the old result, the next read hits.
REQ-037 Reset asserted with redirectD = 1 on the same edge -> pcF = RESET_PC and all previously installed entries miss.
